pattern_test_ctrl: RTL and testbench
====================================

PATTERN_TEST_CTRL -- requirements
Module: pattern_test_ctrl

Interface
REQ-001 Parameter NUM_OPS, default 16, number of write/read-back operations per run (legal range 1..1023).
REQ-002 Port clk input 1: single clock, all state on rising edge.
REQ-003 Port rstn input 1: reset; one clock; reset is asynchronous and active-low.
REQ-004 Port start input 1: pulse in IDLE launches a run; ignored when busy=1.
REQ-005 Port busy output 1: high from the cycle after start is accepted until the run completes.
REQ-006 Port done output 1: one-cycle pulse when the run completes.
REQ-007 Port pass output 1: valid from done onward; 1 when err_count==0; held until next start.
REQ-008 Port err_count output 16: mismatch count for the current run; saturates at 16'hFFFF.
REQ-009 Port first_fail_addr output 10: address of the first mismatch; 10'h000 if none.
REQ-010 Port mem_req output 1: memory request, held until mem_ack.
REQ-011 Port mem_we output 1: 1 = write, 0 = read; stable while mem_req=1.
REQ-012 Port mem_addr output 10: request address; stable while mem_req=1.
REQ-013 Port mem_wdata output 32: write data; stable while mem_req=1.
REQ-014 Port mem_ack input 1: completes the request in the cycle it is sampled high with mem_req=1.
REQ-015 Port mem_rdata input 32: read data, valid in the mem_ack cycle of a read.

Function
REQ-016 Internal 32-bit data LFSR, seed 32'hFFFFFFFF, step: n[0]=o[31], n[1]=o[0]^o[31], n[2]=o[1]^o[31], n[22]=o[21]^o[31], all other bits n[i]=o[i-1].
REQ-017 Internal 10-bit address LFSR, seed 10'h3FF, step: n[0]=o[9], n[3]=o[2]^o[9], all other bits n[i]=o[i-1]; addresses stay unique for up to 1023 steps.
REQ-018 Both LFSRs advance only on an acknowledged request (mem_req & mem_ack); otherwise they hold.
REQ-019 FSM states: IDLE, WRITE, RESEED, READ, FINISH.
REQ-020 IDLE: on start, reseed both LFSRs, clear err_count, first_fail_addr and pass, clear the op counter, and go to WRITE.
REQ-021 WRITE: drive mem_req=1, mem_we=1, mem_addr=addr LFSR, mem_wdata=data LFSR; on ack, increment the op counter; after ack number NUM_OPS, go to RESEED.
REQ-022 RESEED: one cycle with mem_req=0; reload both seeds; clear the op counter; go to READ.
REQ-023 READ: drive mem_req=1, mem_we=0, mem_addr=addr LFSR; on ack, compare mem_rdata with data LFSR.
REQ-024 On a READ mismatch, increment err_count with saturation; capture first_fail_addr only on the first mismatch of the run.
REQ-025 After read ack number NUM_OPS, go to FINISH.
REQ-026 FINISH: one cycle; done=1, busy=0, pass=(err_count==0) including the final compare; return to IDLE.
REQ-027 mem_req deasserts in the cycle after the final ack of each phase; there are no back-to-back requests across a phase boundary.
REQ-028 An ack with mem_req=0 is ignored.
REQ-029 A start during busy is ignored.
REQ-030 A start in the FINISH cycle is ignored.

Reset
REQ-031 While rstn=0: state=IDLE and all outputs 0 (busy, done, pass, err_count, first_fail_addr, mem_req, mem_we, mem_addr, mem_wdata).
REQ-032 While rstn=0: the LFSRs hold their seeds and the op counter is 0.
REQ-033 Reset asserted mid-run aborts the run immediately and drops mem_req asynchronously; no done pulse is produced.

Structure
REQ-034 Shared package pattern_test_pkg holds the FSM state enum, the seed constants (32'hFFFFFFFF, 10'h3FF) and the tap positions.
REQ-035 One sub-module, lfsr_step, implements a parameterised width and tap mask with synchronous enable and seed load; it is instantiated once for data and once for address.

Verification
REQ-036 Reset, start with NUM_OPS=2 and an ideal memory (ack the cycle after req) -> writes (3FF, FFFFFFFF) then (3F7, FFBFFFF9); reads the same addresses in order; done pulses; pass=1; err_count=0.
REQ-037 Memory with bit 0 stuck at 0 on read, NUM_OPS=16 -> err_count equals the number of written words with bit 0 set; first_fail_addr=3FF; pass=0.
REQ-038 Random ack delays of 0-5 cycles -> mem_addr, mem_wdata and mem_we stay stable while mem_req=1 and mem_ack=0; results match REQ-036.
REQ-039 start pulsed during WRITE, and a spurious ack with mem_req=0 -> no effect on the sequence or on the counts.
REQ-040 rstn dropped during READ -> mem_req=0 immediately, no done pulse; a new start afterwards completes with pass=1.
REQ-041 Memory always mismatching, NUM_OPS=1023, err_count preloaded via force to FFFE -> err_count saturates at FFFF.

Source files
------------

// File: rtl/pattern_test_pkg.sv
// Shared definitions for the pattern test controller: FSM states, LFSR seeds
// and tap masks, plus a saturating counter helper.
package pattern_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_RESEED = 3'd2,
    ST_READ   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int ERR_W  = 16;

  localparam logic [DATA_W-1:0] DATA_SEED = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] ADDR_SEED = 10'h3FF;

  // Bit i set means n[i] additionally XORs in the old MSB (bit 0 always takes the MSB).
  localparam logic [DATA_W-1:0] DATA_TAPS = 32'h0040_0006;
  localparam logic [ADDR_W-1:0] ADDR_TAPS = 10'h008;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
    logic [ERR_W-1:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Galois-style LFSR register with seed load (priority) and step enable;
// also exposes the next value so callers can pre-register it.
module lfsr_step #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] next_s;

  // Rotate left, then fold the old MSB into the tap positions.
  always_comb begin
    next_s = {state_r[WIDTH-2:0], state_r[WIDTH-1]} ^ (TAPS & {WIDTH{state_r[WIDTH-1]}});
  end

  // State register: reset and load both return to the seed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= SEED;
    end else if (load) begin
      state_r <= SEED;
    end else if (en) begin
      state_r <= next_s;
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;
  assign next  = next_s;

endmodule

// File: rtl/pattern_test_ctrl.sv
// Memory pattern tester: writes an LFSR data stream to LFSR addresses, then
// reads them back in the same order and counts mismatches.
module pattern_test_ctrl
  import pattern_test_pkg::*;
#(
  parameter int NUM_OPS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [9:0]  first_fail_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [9:0] LAST_OP = 10'(NUM_OPS - 1);

  state_t             state_r;
  logic [9:0]         op_cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
  logic [ERR_W-1:0]   err_count_r;
  logic [ADDR_W-1:0]  first_fail_addr_r;
  logic               err_seen_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;

  logic               ack_s;
  logic               reseed_s;
  logic               mismatch_s;
  logic [ERR_W-1:0]   err_next_s;
  logic [DATA_W-1:0]  data_q_s;
  logic [DATA_W-1:0]  data_next_s;
  logic [ADDR_W-1:0]  addr_q_s;
  logic [ADDR_W-1:0]  addr_next_s;

  // Handshake qualification, seed reloads and read-back comparison.
  always_comb begin
    ack_s      = mem_req_r & mem_ack;
    reseed_s   = ((state_r == ST_IDLE) && start) || (state_r == ST_RESEED);
    mismatch_s = (state_r == ST_READ) && ack_s && (mem_rdata != data_q_s);
    if (mismatch_s) begin
      err_next_s = sat_inc(err_count_r);
    end else begin
      err_next_s = err_count_r;
    end
  end

  lfsr_step #(
    .WIDTH (DATA_W),
    .TAPS  (DATA_TAPS),
    .SEED  (DATA_SEED)
  ) u_data_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (reseed_s),
    .en    (ack_s),
    .state (data_q_s),
    .next  (data_next_s)
  );

  lfsr_step #(
    .WIDTH (ADDR_W),
    .TAPS  (ADDR_TAPS),
    .SEED  (ADDR_SEED)
  ) u_addr_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (reseed_s),
    .en    (ack_s),
    .state (addr_q_s),
    .next  (addr_next_s)
  );

  // Control FSM; the request registers mirror the LFSRs by loading their next values on ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r           <= ST_IDLE;
      op_cnt_r          <= 10'd0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      pass_r            <= 1'b0;
      err_count_r       <= 16'h0000;
      first_fail_addr_r <= 10'h000;
      err_seen_r        <= 1'b0;
      mem_req_r         <= 1'b0;
      mem_we_r          <= 1'b0;
      mem_addr_r        <= 10'h000;
      mem_wdata_r       <= 32'h0000_0000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r           <= ST_WRITE;
            op_cnt_r          <= 10'd0;
            busy_r            <= 1'b1;
            pass_r            <= 1'b0;
            err_count_r       <= 16'h0000;
            first_fail_addr_r <= 10'h000;
            err_seen_r        <= 1'b0;
            mem_req_r         <= 1'b1;
            mem_we_r          <= 1'b1;
            mem_addr_r        <= ADDR_SEED;
            mem_wdata_r       <= DATA_SEED;
          end
        end
        ST_WRITE: begin
          if (ack_s) begin
            if (op_cnt_r == LAST_OP) begin
              state_r   <= ST_RESEED;
              op_cnt_r  <= 10'd0;
              mem_req_r <= 1'b0;
              mem_we_r  <= 1'b0;
            end else begin
              op_cnt_r    <= op_cnt_r + 10'd1;
              mem_addr_r  <= addr_next_s;
              mem_wdata_r <= data_next_s;
            end
          end
        end
        ST_RESEED: begin
          state_r    <= ST_READ;
          op_cnt_r   <= 10'd0;
          mem_req_r  <= 1'b1;
          mem_we_r   <= 1'b0;
          mem_addr_r <= ADDR_SEED;
        end
        ST_READ: begin
          if (ack_s) begin
            err_count_r <= err_next_s;
            if (mismatch_s && !err_seen_r) begin
              first_fail_addr_r <= addr_q_s;
              err_seen_r        <= 1'b1;
            end
            if (op_cnt_r == LAST_OP) begin
              state_r   <= ST_FINISH;
              op_cnt_r  <= 10'd0;
              mem_req_r <= 1'b0;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              pass_r    <= (err_next_s == 16'h0000);
            end else begin
              op_cnt_r   <= op_cnt_r + 10'd1;
              mem_addr_r <= addr_next_s;
            end
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign err_count       = err_count_r;
  assign first_fail_addr = first_fail_addr_r;
  assign mem_req         = mem_req_r;
  assign mem_we          = mem_we_r;
  assign mem_addr        = mem_addr_r;
  assign mem_wdata       = mem_wdata_r;

endmodule

// File: tb/tb_pattern_test_ctrl.sv
// Self-checking bench: randomized-latency memory responder, reference
// sequence from LFSR polynomials, and a second instance for saturation.
module tb_pattern_test_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [9:0]  first_fail_addr;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        b_start;
  logic        b_busy, b_done, b_pass;
  logic [15:0] b_err_count;
  logic [9:0]  b_first_fail_addr;
  logic        b_mem_req, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic        b_mem_ack;
  logic [31:0] b_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // responder configuration
  int mode = 0;          // 0 ideal, 1 bit0 stuck at 0, 2 always wrong
  int min_delay = 1;
  int max_delay = 1;
  bit spur_en = 1'b0;

  logic [31:0] mem [1024];
  bit          log_we[$];
  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];

  logic [9:0]  exp_addr [N];
  logic [31:0] exp_data [N];

  always #5 clk = ~clk;

  pattern_test_ctrl #(.NUM_OPS(N)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_addr(first_fail_addr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  pattern_test_ctrl #(.NUM_OPS(1023)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(b_start), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err_count), .first_fail_addr(b_first_fail_addr), .mem_req(b_mem_req),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack),
    .mem_rdata(b_mem_rdata)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] data_step(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? 32'h0040_0007 : 32'h0000_0000);
  endfunction

  function automatic logic [9:0] addr_step(input logic [9:0] x);
    return (x << 1) ^ (x[9] ? 10'h009 : 10'h000);
  endfunction

  function automatic logic [31:0] read_word(input logic [9:0] a);
    case (mode)
      1:       return mem[a] & 32'hFFFF_FFFE;
      2:       return ~mem[a];
      default: return mem[a];
    endcase
  endfunction

  // Memory model: random ack latency per request, logs each acked transfer, checks request stability.
  task automatic responder();
    int wait_cnt = 0;
    bit pending = 1'b0;
    bit acked = 1'b0;
    logic [9:0] p_addr = 10'h000;
    logic [31:0] p_wdata = 32'h0;
    logic p_we = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (acked) begin
        acked = 1'b0;
        pending = 1'b0;
      end
      if (rstn !== 1'b1 || mem_req !== 1'b1) begin
        pending = 1'b0;
        if (spur_en && rstn === 1'b1) mem_ack = 1'b1;
      end else begin
        if (!pending) begin
          pending = 1'b1;
          wait_cnt = int'($urandom_range(max_delay, min_delay));
          p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        end else begin
          check("stable_addr", {22'h0, mem_addr}, {22'h0, p_addr});
          check("stable_we", {31'h0, mem_we}, {31'h0, p_we});
          check("stable_wdata", mem_wdata, p_wdata);
        end
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          acked = 1'b1;
          log_we.push_back(mem_we);
          log_addr.push_back(mem_addr);
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            log_data.push_back(mem_wdata);
          end else begin
            mem_rdata = read_word(mem_addr);
            log_data.push_back(mem_rdata);
          end
        end else begin
          wait_cnt--;
        end
      end
    end
  endtask

  task automatic clear_logs();
    log_we.delete(); log_addr.delete(); log_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_pass"}, {31'h0, pass}, 32'h0);
    check({tag, "_err"}, {16'h0, err_count}, 32'h0);
    check({tag, "_ffa"}, {22'h0, first_fail_addr}, 32'h0);
    check({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_addr"}, {22'h0, mem_addr}, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'h1);
  endtask

  // Run one test after start; optionally re-pulse start mid-write.
  task automatic run_and_check(input string tag, input bit restart_mid, input logic [15:0] exp_err,
                               input logic [9:0] exp_ffa, input bit exp_pass);
    int budget;
    bit got_done;
    int done_before;
    clear_logs();
    done_before = done_cnt;
    pulse_start();
    if (restart_mid) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got_done = 1'b0;
    budget = 0;
    while (!got_done && budget < 2000) begin
      if (done === 1'b1) got_done = 1'b1;
      else begin @(negedge clk); budget++; end
    end
    check({tag, "_done_seen"}, {31'h0, got_done}, 32'h1);
    check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    check({tag, "_err"}, {16'h0, err_count}, {16'h0, exp_err});
    check({tag, "_ffa"}, {22'h0, first_fail_addr}, {22'h0, exp_ffa});
    check({tag, "_pass"}, {31'h0, pass}, {31'h0, exp_pass});
    check({tag, "_ntrans"}, log_we.size(), 2 * N);
    if (log_we.size() == 2 * N) begin
      for (int i = 0; i < N; i++) begin
        check({tag, "_w_we"}, {31'h0, log_we[i]}, 32'h1);
        check({tag, "_w_addr"}, {22'h0, log_addr[i]}, {22'h0, exp_addr[i]});
        check({tag, "_w_data"}, log_data[i], exp_data[i]);
        check({tag, "_r_we"}, {31'h0, log_we[N+i]}, 32'h0);
        check({tag, "_r_addr"}, {22'h0, log_addr[N+i]}, {22'h0, exp_addr[i]});
      end
    end
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'h0, done}, 32'h0);
    check({tag, "_pass_hold"}, {31'h0, pass}, {31'h0, exp_pass});
    check({tag, "_done_count"}, done_cnt - done_before, 32'd1);
    check({tag, "_req_idle"}, {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    int n_bit0;
    logic [9:0] ffa_bit0;
    bit found;
    int budget;
    bit seen;

    start = 1'b0; b_start = 1'b0; b_mem_ack = 1'b1; b_mem_rdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // reference sequence
    exp_addr[0] = 10'h3FF;
    exp_data[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < N; i++) begin
      exp_addr[i] = addr_step(exp_addr[i-1]);
      exp_data[i] = data_step(exp_data[i-1]);
    end
    n_bit0 = 0; ffa_bit0 = 10'h000; found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (exp_data[i][0]) begin
        n_bit0++;
        if (!found) begin ffa_bit0 = exp_addr[i]; found = 1'b1; end
      end
    end

    rstn = 1'b1;
    #1 rstn = 1'b0;
    fork responder(); join_none
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;

    // ideal memory, ack one cycle after request
    mode = 0; min_delay = 1; max_delay = 1;
    run_and_check("ideal", 1'b0, 16'h0000, 10'h000, 1'b1);
    check("first_write_addr", 32'h3FF, {22'h0, exp_addr[0]});
    check("second_write_addr", 32'h3F7, {22'h0, exp_addr[1]});
    check("second_write_data", 32'hFFBF_FFF9, exp_data[1]);

    // bit 0 stuck at 0 on read
    mode = 1;
    run_and_check("stuck0", 1'b0, 16'(n_bit0), ffa_bit0, 1'b0);
    check("stuck0_ffa_seed", {22'h0, first_fail_addr}, 32'h3FF);

    // random latency, start during write, spurious acks while idle/reseeding
    mode = 0; min_delay = 0; max_delay = 5; spur_en = 1'b1;
    run_and_check("random", 1'b1, 16'h0000, 10'h000, 1'b1);
    spur_en = 1'b0;

    // reset during read phase
    min_delay = 0; max_delay = 3;
    clear_logs();
    budget = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b0) seen = 1'b1;
    end
    check("reached_read", {31'h0, seen}, 32'h1);
    #2 rstn = 1'b0;
    #1 check("async_req_drop", {31'h0, mem_req}, 32'h0);
    repeat (2) @(negedge clk);
    check_reset_outputs("midrun_reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_on_abort", done_cnt - budget, 32'd0);
    run_and_check("after_reset", 1'b0, 16'h0000, 10'h000, 1'b1);

    // saturation on a 1023-op run whose memory always returns zero
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1200 && !seen; c++) begin
      @(negedge clk);
      if (b_mem_req === 1'b1 && b_mem_we === 1'b0) seen = 1'b1;
    end
    check("sat_reached_read", {31'h0, seen}, 32'h1);
    force u_dut2.err_count_r = 16'hFFFE;
    @(negedge clk);
    release u_dut2.err_count_r;
    seen = 1'b0;
    for (int c = 0; c < 1200 && !seen; c++) begin
      @(negedge clk);
      if (b_done === 1'b1) seen = 1'b1;
    end
    check("sat_done", {31'h0, seen}, 32'h1);
    check("sat_err", {16'h0, b_err_count}, 32'h0000_FFFF);
    check("sat_pass", {31'h0, b_pass}, 32'h0);
    check("sat_ffa", {22'h0, b_first_fail_addr}, 32'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
